// File: rtl/div32.sv
// Sequential sign-magnitude 32/32 restoring divider (bit 31 sign, 30:0 magnitude).
// Latency: done 33 enabled cycles after an accepted start; 2 cycles for divide-by-zero.
// Backpressure: en low freezes all state; start is accepted only when idle, never queued.
module div32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        start,
  input  logic [31:0] num1,
  input  logic [31:0] num2,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done,
  output logic        busy,
  output logic        div_by_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic        s1;
  logic        s2;
  logic [30:0] a;
  logic [30:0] b;
  logic [30:0] q;
  logic [31:0] r;
  logic [4:0]  cnt;
  logic        dz;

  // Partial remainder after shifting in the next dividend bit; at most 32 bits wide.
  logic [31:0] r_shift;
  logic [31:0] r_sub;
  logic        r_ge;

  // One restoring step: trial-subtract the divisor from the shifted remainder.
  always_comb begin
    r_shift = {r[30:0], a[cnt]};
    r_sub   = r_shift - {1'b0, b};
    r_ge    = (r_shift >= {1'b0, b});
  end

  assign busy = (state == S_RUN);

  // Control FSM, datapath registers and output registers, all gated by en.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      s1          <= 1'b0;
      s2          <= 1'b0;
      a           <= '0;
      b           <= '0;
      q           <= '0;
      r           <= '0;
      cnt         <= '0;
      dz          <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (en) begin
      // done is a one-cycle pulse following the DONE state.
      done <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            s1  <= num1[31];
            s2  <= num2[31];
            a   <= num1[30:0];
            b   <= num2[30:0];
            q   <= '0;
            r   <= '0;
            cnt <= 5'd30;
            // Both +0 and -0 divisors short-circuit straight to completion.
            if (num2[30:0] == 31'd0) begin
              dz    <= 1'b1;
              state <= S_DONE;
            end else begin
              dz    <= 1'b0;
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (r_ge) begin
            r      <= r_sub;
            q[cnt] <= 1'b1;
          end else begin
            r      <= r_shift;
            q[cnt] <= 1'b0;
          end
          if (cnt == 5'd0) begin
            state <= S_DONE;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        S_DONE: begin
          if (dz) begin
            // Saturate the quotient magnitude and hand back the dividend unchanged.
            quotient    <= {s1 ^ s2, 31'h7FFF_FFFF};
            remainder   <= {s1, a};
            div_by_zero <= 1'b1;
          end else begin
            // Sign bits are suppressed on zero magnitudes so -0 never appears;
            // the remainder follows the dividend sign (truncating division).
            quotient    <= {(s1 ^ s2) & (|q), q};
            remainder   <= {s1 & (|r[30:0]), r[30:0]};
            div_by_zero <= 1'b0;
          end
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div32.sv
// Directed bench for div32: hand-computed quotients/remainders, latency and busy counts.
// Stimulus changes on the falling edge; outputs are sampled 1 time unit after the rising edge.
// en pauses, ignored restarts and a mid-run reset are exercised alongside the arithmetic.
module tb_div32;

  logic        clk;
  logic        rst;
  logic        en;
  logic        start;
  logic [31:0] num1;
  logic [31:0] num2;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        done;
  logic        busy;
  logic        div_by_zero;

  int n_chk;
  int n_pass;

  div32 dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .start       (start),
    .num1        (num1),
    .num2        (num2),
    .quotient    (quotient),
    .remainder   (remainder),
    .done        (done),
    .busy        (busy),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Launch one division and follow it to done, counting cycles from the accept edge.
  // pause_at/pause_len drop en for a window; restart_at pulses a stray start mid-run.
  task automatic run_div(input string tag,
                         input logic [31:0] n1, input logic [31:0] n2,
                         input logic [31:0] eq, input logic [31:0] er, input logic edz,
                         input int elat, input int ebusy,
                         input int pause_at, input int pause_len, input int restart_at);
    int k;
    int busy_cnt;
    logic [31:0] q_seen;
    @(negedge clk);
    num1  = n1;
    num2  = n2;
    start = 1'b1;
    en    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    num1     = $urandom;
    num2     = $urandom;
    k        = 1;
    busy_cnt = 0;
    while (!done && k < 200) begin
      en    = !(pause_at != 0 && k >= pause_at && k < pause_at + pause_len);
      start = (restart_at != 0 && k == restart_at);
      if (start) begin
        num1 = 32'h0000_0009;
        num2 = 32'h0000_0003;
      end
      if (busy && en) busy_cnt++;
      @(posedge clk);
      #1;
      k++;
    end
    en    = 1'b1;
    start = 1'b0;
    chk({tag, " latency"}, k, elat);
    chk({tag, " busy_cycles"}, busy_cnt, ebusy);
    chk({tag, " quotient"}, quotient, eq);
    chk({tag, " remainder"}, remainder, er);
    chk({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, edz});
    q_seen = quotient;
    // done must survive a disabled edge and clear on the next enabled one.
    en = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, " done_held_en_low"}, {31'd0, done}, 32'd1);
    en = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, " done_single_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, " quotient_stable"}, quotient, q_seen);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    en     = 1'b1;
    start  = 1'b0;
    num1   = '0;
    num2   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset quotient", quotient, 32'd0);
    chk("reset remainder", remainder, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset dz", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;

    //      tag           num1           num2           quotient       remainder     dz  lat bsy
    run_div("p100_7",     32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 32'h0000_0002, 0, 33, 31, 0, 0, 0);
    run_div("n100_7",     32'h8000_0064, 32'h0000_0007, 32'h8000_000E, 32'h8000_0002, 0, 33, 31, 0, 0, 0);
    run_div("n100_n7",    32'h8000_0064, 32'h8000_0007, 32'h0000_000E, 32'h8000_0002, 0, 33, 31, 0, 0, 0);
    run_div("p5_n9",      32'h0000_0005, 32'h8000_0009, 32'h0000_0000, 32'h0000_0005, 0, 33, 31, 0, 0, 0);
    run_div("n14_7",      32'h8000_000E, 32'h0000_0007, 32'h8000_0002, 32'h0000_0000, 0, 33, 31, 0, 0, 0);
    run_div("max_1",      32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 32'h0000_0000, 0, 33, 31, 0, 0, 0);
    run_div("p3_max",     32'h0000_0003, 32'h7FFF_FFFF, 32'h0000_0000, 32'h0000_0003, 0, 33, 31, 0, 0, 0);
    run_div("dz_neg0",    32'h8000_0010, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0010, 1, 2, 0, 0, 0, 0);
    run_div("dz_n7_pos0", 32'h8000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0007, 1, 2, 0, 0, 0, 0);
    run_div("pause",      32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 32'h0000_0002, 0, 43, 31, 10, 10, 25);

    // Abort a division part way through with reset; outputs were nonzero beforehand.
    @(negedge clk);
    num1  = 32'h0000_0064;
    num2  = 32'h0000_0007;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("abort busy_before_rst", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort quotient", quotient, 32'd0);
    chk("abort remainder", remainder, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort dz", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;
    // Start in the first cycle after reset release; an aborted run would finish too early.
    run_div("post_rst",   32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 32'h0000_0002, 0, 33, 31, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
